// File: rtl/branch_predictor.sv
// ============================================================================
//  Module      : branch_predictor
//  Description : gshare direction predictor (2-bit counters indexed by
//                PC ^ GHR) plus a direct-mapped BTB for the fetch stage.
//                Prediction is combinational from registered state; training
//                comes from execute-stage resolution. The GHR is shifted
//                speculatively on conditional BTB hits and repaired on
//                mispredict.
//                Optional feature macro: BRANCH_PERF_EN (adds perf_total and
//                perf_correct resolution counters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int BTB_ENTRIES = 64,
  parameter int BHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid,
  input  logic [63:0]         pred_pc,
  output logic                pred_taken,
  output logic [63:0]         pred_target,
  output logic                pred_hit,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [63:0]         upd_pc,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic [63:0]         upd_target,
  input  logic                upd_mispredict,
  input  logic [GHR_BITS-1:0] upd_ghr
`ifdef BRANCH_PERF_EN
  ,
  output logic [63:0]         perf_total,
  output logic [63:0]         perf_correct
`endif
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W     = 64 - BTB_IDX_W - 2;

  // Architectural state
  logic [BTB_ENTRIES-1:0]      btb_valid;
  logic [TAG_W-1:0]            btb_tag    [BTB_ENTRIES];
  logic [63:0]                 btb_target [BTB_ENTRIES];
  logic                        btb_cond   [BTB_ENTRIES];
  logic [BHT_ENTRIES-1:0][1:0] bht;
  logic [GHR_BITS-1:0]         ghr;

  // Index / tag derivation
  logic [BTB_IDX_W-1:0] pred_btb_idx;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic [TAG_W-1:0]     pred_tag;
  logic [TAG_W-1:0]     upd_tag;
  logic [BHT_IDX_W-1:0] ghr_ext;
  logic [BHT_IDX_W-1:0] upd_ghr_ext;
  logic [BHT_IDX_W-1:0] pred_bht_idx;
  logic [BHT_IDX_W-1:0] upd_bht_idx;
  logic [1:0]           pred_ctr;
  logic [1:0]           upd_ctr;
  logic [1:0]           upd_ctr_next;
  logic                 pred_is_cond;
  logic [GHR_BITS-1:0]  ghr_repair_cond;
  logic [GHR_BITS-1:0]  ghr_spec_shift;

  // Low PC bits never contribute to indexing (4-byte aligned instructions).
  logic unused_pc_bits;
  assign unused_pc_bits = ^upd_pc[1:0];

  assign pred_btb_idx = pred_pc[BTB_IDX_W+1:2];
  assign upd_btb_idx  = upd_pc[BTB_IDX_W+1:2];
  assign pred_tag     = pred_pc[63:BTB_IDX_W+2];
  assign upd_tag      = upd_pc[63:BTB_IDX_W+2];

  // Zero-extend the history registers to the counter-table index width
  always_comb begin
    ghr_ext                    = '0;
    ghr_ext[GHR_BITS-1:0]      = ghr;
    upd_ghr_ext                = '0;
    upd_ghr_ext[GHR_BITS-1:0]  = upd_ghr;
  end

  assign pred_bht_idx = pred_pc[BHT_IDX_W+1:2] ^ ghr_ext;
  assign upd_bht_idx  = upd_pc[BHT_IDX_W+1:2] ^ upd_ghr_ext;
  assign pred_ctr     = bht[pred_bht_idx];
  assign upd_ctr      = bht[upd_bht_idx];

  // Prediction path: combinational from registered state, independent of pred_valid
  assign pred_is_cond = btb_cond[pred_btb_idx];
  assign pred_hit     = btb_valid[pred_btb_idx] && (btb_tag[pred_btb_idx] == pred_tag);
  assign pred_taken   = pred_hit && (pred_is_cond ? pred_ctr[1] : 1'b1);
  assign pred_target  = pred_taken ? btb_target[pred_btb_idx] : (pred_pc + 64'd4);
  assign pred_ghr     = ghr;

  // Saturating counter next value for the resolved branch
  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
    end
  end

  // History shift forms; a one-bit history degenerates to just the new outcome
  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_repair_cond = upd_taken;
      assign ghr_spec_shift  = pred_taken;
    end else begin : g_ghr_wide
      assign ghr_repair_cond = {upd_ghr[GHR_BITS-2:0], upd_taken};
      assign ghr_spec_shift  = {ghr[GHR_BITS-2:0], pred_taken};
    end
  endgenerate

  // Counter table: reset to weakly not-taken, train on resolved conditional branches
  always_ff @(posedge clk) begin
    if (reset) begin
      bht <= {BHT_ENTRIES{2'b01}};
    end else if (upd_valid && upd_is_cond) begin
      bht[upd_bht_idx] <= upd_ctr_next;
    end
  end

  // BTB valid bits: cleared on reset, set by any taken resolution
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[upd_btb_idx] <= 1'b1;
    end
  end

  // BTB payload: no reset needed since valid gates every use
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      btb_tag[upd_btb_idx]    <= upd_tag;
      btb_target[upd_btb_idx] <= upd_target;
      btb_cond[upd_btb_idx]   <= upd_is_cond;
    end
  end

  // Global history: repair beats speculative shift; stalled fetch leaves it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid && upd_mispredict && upd_is_cond) begin
      ghr <= ghr_repair_cond;
    end else if (upd_valid && upd_mispredict && !upd_is_cond) begin
      ghr <= upd_ghr;
    end else if (pred_valid && pred_hit && pred_is_cond) begin
      ghr <= ghr_spec_shift;
    end
  end

`ifdef BRANCH_PERF_EN
  // Resolution statistics, free-running with natural 64-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_total   <= '0;
      perf_correct <= '0;
    end else if (upd_valid) begin
      perf_total <= perf_total + 64'd1;
      if (!upd_mispredict) perf_correct <= perf_correct + 64'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor with
//                hand-computed expected values (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  localparam int GHR_BITS = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                pred_valid;
  logic [63:0]         pred_pc;
  logic                pred_taken;
  logic [63:0]         pred_target;
  logic                pred_hit;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_valid;
  logic [63:0]         upd_pc;
  logic                upd_is_cond;
  logic                upd_taken;
  logic [63:0]         upd_target;
  logic                upd_mispredict;
  logic [GHR_BITS-1:0] upd_ghr;
`ifdef BRANCH_PERF_EN
  logic [63:0]         perf_total;
  logic [63:0]         perf_correct;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .BTB_ENTRIES(64),
    .BHT_ENTRIES(256),
    .GHR_BITS   (GHR_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_hit      (pred_hit),
    .pred_ghr      (pred_ghr),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_is_cond   (upd_is_cond),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .upd_ghr       (upd_ghr)
`ifdef BRANCH_PERF_EN
    ,
    .perf_total    (perf_total),
    .perf_correct  (perf_correct)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One resolved update applied at the next clock edge
  task automatic do_upd(input logic [63:0] pc, input logic is_cond, input logic taken,
                        input logic [63:0] target, input logic mis, input logic [7:0] ghr_in);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_cond    = is_cond;
    upd_taken      = taken;
    upd_target     = target;
    upd_mispredict = mis;
    upd_ghr        = ghr_in;
    @(posedge clk); #1;
    upd_valid      = 1'b0;
  endtask

  // Present a PC (no state change) and compare the prediction outputs
  task automatic predict(input string tag, input logic [63:0] pc, input logic hit,
                         input logic taken, input logic [63:0] target);
    pred_pc = pc;
    #1;
    check({tag, ".hit"},    {63'd0, pred_hit},   {63'd0, hit});
    check({tag, ".taken"},  {63'd0, pred_taken}, {63'd0, taken});
    check({tag, ".target"}, pred_target,         target);
  endtask

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; upd_ghr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    predict("rst", 64'h8000_0000, 1'b0, 1'b0, 64'h8000_0004);
    check("rst.ghr", {56'd0, pred_ghr}, 64'h0);

    // First cond taken mispredict: counter idx 4 -> 2, GHR repaired to 0x01
    do_upd(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 1'b1, 8'h00);
    check("first.ghr", {56'd0, pred_ghr}, 64'h01);
    // With GHR=1 the lookup lands on idx 5 (still 01): hit but not taken
    predict("first", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);

    // jal mispredict repairs GHR to 0 and installs a target
    do_upd(64'h8000_0020, 1'b0, 1'b1, 64'h8000_0400, 1'b1, 8'h00);
    check("jal.ghr", {56'd0, pred_ghr}, 64'h00);
    predict("jal", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
    predict("ctr2", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);

    // Decrement 2->1->0->0->0, then climb back
    do_upd(64'h8000_0010, 1'b1, 1'b0, 64'h0, 1'b0, 8'h00);
    predict("ctr1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    for (int i = 0; i < 3; i++) do_upd(64'h8000_0010, 1'b1, 1'b0, 64'h0, 1'b0, 8'h00);
    predict("ctr0", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    do_upd(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 1'b0, 8'h00);
    predict("inc1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    do_upd(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 1'b0, 8'h00);
    predict("inc2", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);
    // Saturate at 3, one decrement leaves 2 (still taken)
    for (int i = 0; i < 2; i++) do_upd(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 1'b0, 8'h00);
    do_upd(64'h8000_0010, 1'b1, 1'b0, 64'h0, 1'b0, 8'h00);
    predict("sat3", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);

    // BTB aliasing: 0x...120 shares index 8 with 0x...020
    predict("alias.pre", 64'h8000_0120, 1'b0, 1'b0, 64'h8000_0124);
    do_upd(64'h8000_0120, 1'b0, 1'b1, 64'h8000_0800, 1'b0, 8'h00);
    predict("alias.new", 64'h8000_0120, 1'b1, 1'b1, 64'h8000_0800);
    predict("alias.old", 64'h8000_0020, 1'b0, 1'b0, 64'h8000_0024);

    // GHR to 0x05 via jump repair, then train counter idx 4^5=1 to taken
    do_upd(64'h8000_0200, 1'b0, 1'b1, 64'h8000_0A00, 1'b1, 8'h05);
    check("ghr5", {56'd0, pred_ghr}, 64'h05);
    do_upd(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 1'b0, 8'h05);
    predict("spec.pre", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);

    // Speculative shift (would give 0x0B) collides with cond repair -> 0x06
    pred_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h8000_0300; upd_is_cond = 1'b1; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b1; upd_ghr = 8'h03;
    @(posedge clk); #1;
    pred_valid = 1'b0; upd_valid = 1'b0;
    check("repair.ghr", {56'd0, pred_ghr}, 64'h06);

    // Lone speculative shift: idx 4^6=2 holds 01, not taken -> GHR 0x0C
    pred_valid = 1'b1;
    @(posedge clk); #1;
    pred_valid = 1'b0;
    check("spec.ghr", {56'd0, pred_ghr}, 64'h0C);
    // Stall holds, and a valid miss does not shift
    @(posedge clk); #1;
    check("stall.ghr", {56'd0, pred_ghr}, 64'h0C);
    pred_pc = 64'h8000_0400; pred_valid = 1'b1;
    @(posedge clk); #1;
    pred_valid = 1'b0;
    check("miss.ghr", {56'd0, pred_ghr}, 64'h0C);

    // Reset coinciding with an update drops the update
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h8000_0500; upd_is_cond = 1'b0; upd_taken = 1'b1;
    upd_target = 64'h8000_0900; upd_mispredict = 1'b1; upd_ghr = 8'h33;
    @(posedge clk); #1;
    reset = 1'b0; upd_valid = 1'b0;
    predict("rst2.drop", 64'h8000_0500, 1'b0, 1'b0, 64'h8000_0504);
    predict("rst2.old", 64'h8000_0010, 1'b0, 1'b0, 64'h8000_0014);
    check("rst2.ghr", {56'd0, pred_ghr}, 64'h00);

`ifdef BRANCH_PERF_EN
    check("perf.rst.total", perf_total, 64'd0);
    for (int i = 0; i < 10; i++)
      do_upd(64'h8000_1000, 1'b1, 1'b0, 64'h0, (i % 3 == 0 && i < 9), 8'h00);
    check("perf.total", perf_total, 64'd10);
    check("perf.correct", perf_correct, 64'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("perf.clr.total", perf_total, 64'd0);
    check("perf.clr.correct", perf_correct, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
